// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray/binary converter.
package gray_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Widest code word the helper below can inspect.
  localparam int GRAY_MAX_WIDTH = 64;

  // True iff exactly one bit of vec is set.
  function automatic logic gray_popcount_is_one(input logic [GRAY_MAX_WIDTH-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/gray_adj_checker.sv
// Keeps the last accepted Gray->binary word and flags words that are not
// exactly one bit away from it. The flag is combinational on the incoming word.
module gray_adj_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic             err
);

  logic [WIDTH-1:0] prev;
  logic             has_prev;

  // Distance check only applies to G2B words that have a G2B predecessor.
  always_comb begin
    err = 1'b0;
    if (mode == MODE_G2B && has_prev) begin
      err = !gray_popcount_is_one(GRAY_MAX_WIDTH'(data ^ prev));
    end
  end

  // History: a G2B word becomes the new reference, a B2G word breaks the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      has_prev <= 1'b0;
    end else if (accept) begin
      if (mode == MODE_G2B) begin
        prev     <= data;
        has_prev <= 1'b1;
      end else begin
        has_prev <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gray_code_converter_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready handshake.
// All stages share one advance enable; G2B resolves one MSB-first chunk per stage.
module gray_code_converter_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             adj_err
);

  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  logic             adv;
  logic             adj_bit;
  logic             valid_reg [STAGES];
  logic             mode_reg  [STAGES];
  logic             err_reg   [STAGES];
  logic [WIDTH-1:0] data_reg  [STAGES];
  logic [WIDTH-1:0] conv      [STAGES];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  gray_adj_checker #(.WIDTH(WIDTH)) u_adj (
    .clk    (clk),
    .rst    (rst),
    .accept (in_valid & adv),
    .mode   (in_mode),
    .data   (in_data),
    .err    (adj_bit)
  );

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Bit range of the chunk this stage resolves; empty when HI < LO.
      localparam int HI     = WIDTH - 1 - gi * CHUNK;
      localparam int LO_RAW = WIDTH - (gi + 1) * CHUNK;
      localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;

      logic [WIDTH-1:0] word_in;
      logic             mode_in;

      if (gi == 0) begin : g_first
        assign word_in = in_data;
        assign mode_in = in_mode;
      end else begin : g_rest
        assign word_in = data_reg[gi-1];
        assign mode_in = mode_reg[gi-1];
      end

      // Bits above the chunk are already binary, bits below are still Gray,
      // so each chunk bit is its Gray bit XOR the resolved bit just above.
      always_comb begin : p_conv
        logic [WIDTH-1:0] w;
        w = word_in;
        if (mode_in == MODE_G2B) begin
          for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i <= HI && i >= LO) begin
              w[i] = w[i+1] ^ word_in[i];
            end
          end
        end else if (gi == 0) begin
          w = word_in ^ (word_in >> 1);
        end
        conv[gi] = w;
      end
    end
  endgenerate

  // Pipeline registers: every stage moves together when the output slot frees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_reg[s] <= 1'b0;
        mode_reg[s]  <= 1'b0;
        err_reg[s]   <= 1'b0;
        data_reg[s]  <= '0;
      end
    end else if (adv) begin
      valid_reg[0] <= in_valid;
      mode_reg[0]  <= in_mode;
      err_reg[0]   <= adj_bit;
      data_reg[0]  <= conv[0];
      for (int s = 1; s < STAGES; s++) begin
        valid_reg[s] <= valid_reg[s-1];
        mode_reg[s]  <= mode_reg[s-1];
        err_reg[s]   <= err_reg[s-1];
        data_reg[s]  <= conv[s];
      end
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign out_mode  = mode_reg[STAGES-1];
  assign adj_err   = err_reg[STAGES-1];
  assign out_data  = data_reg[STAGES-1];

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// Bench for gray_code_converter_pipe: reference model plus directed vectors.
module tb_gray_code_converter_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_mode;
  logic       adj_err;

  logic       in5_valid = 1'b0;
  logic [4:0] in5_data = '0;
  logic       in5_mode = 1'b0;
  logic       rdy5a, rdy5b;
  logic       ov5a, ov5b, om5a, om5b, ae5a, ae5b;
  logic [4:0] od5a, od5b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_code_converter_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .adj_err(adj_err)
  );

  gray_code_converter_pipe #(.WIDTH(5), .STAGES(5)) dut5a (
    .clk(clk), .rst(rst), .in_valid(in5_valid), .in_ready(rdy5a),
    .in_data(in5_data), .in_mode(in5_mode), .out_valid(ov5a),
    .out_ready(1'b1), .out_data(od5a), .out_mode(om5a), .adj_err(ae5a)
  );

  gray_code_converter_pipe #(.WIDTH(5), .STAGES(1)) dut5b (
    .clk(clk), .rst(rst), .in_valid(in5_valid), .in_ready(rdy5b),
    .in_data(in5_data), .in_mode(in5_mode), .out_valid(ov5b),
    .out_ready(1'b1), .out_data(od5b), .out_mode(om5b), .adj_err(ae5b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference conversions from the code definitions.
  function automatic logic [7:0] m_b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] m_g2b(input logic [7:0] g);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b = b ^ (g >> k);
    return b;
  endfunction

  typedef struct packed {
    logic [7:0] data;
    logic       mode;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_prev = '0;
  bit         m_has = 1'b0;
  int         out_count = 0;
  int         err_count = 0;
  int         stall_count = 0;
  bit         stalled = 1'b0;
  exp_t       held;

  // Compare process: everything is sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_has   = 1'b0;
        stalled = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (stalled) begin
          check("stall_stable", 32'({out_valid, out_data, out_mode, adj_err}),
                32'({1'b1, held.data, held.mode, held.err}));
        end
        stalled = 1'b0;
        if (out_valid && !out_ready) begin
          stall_count++;
          check("stall_in_ready", 32'(in_ready), 32'd0);
          stalled = 1'b1;
          held    = '{data: out_data, mode: out_mode, err: adj_err};
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            out_count++;
            if (adj_err) err_count++;
            $display("xfer out=%02h mode=%0d err=%0d exp=%02h/%0d/%0d",
                     out_data, out_mode, adj_err, e.data, e.mode, e.err);
            check("xfer", 32'({out_data, out_mode, adj_err}), 32'({e.data, e.mode, e.err}));
          end
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e.mode = in_mode;
          if (in_mode) begin
            e.data = m_g2b(in_data);
            e.err  = m_has && ($countones(in_data ^ m_prev) != 1);
            m_prev = in_data;
            m_has  = 1'b1;
          end else begin
            e.data = m_b2g(in_data);
            e.err  = 1'b0;
            m_has  = 1'b0;
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  // Present one word; returns just after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic m);
    int n = 0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready || n > 100) break;
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result of the word just sent and compare it with literals.
  task automatic wait_out(input logic [7:0] ed, input logic em, input logic ee, input string nm);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (!out_valid) begin
      check({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      $display("word %s out=%02h mode=%0d err=%0d lat=%0d", nm, out_data, out_mode, adj_err, k + 1);
      check({nm, "_data"}, 32'(out_data), 32'(ed));
      check({nm, "_mode"}, 32'(out_mode), 32'(em));
      check({nm, "_err"},  32'(adj_err),  32'(ee));
      check({nm, "_lat"},  k + 1, 32'd2);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_mode",  32'(out_mode),  32'd0);
    check("reset_adj_err",   32'(adj_err),   32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;

    check("model_b2g_0f", 32'(m_b2g(8'h0F)), 32'h08);
    check("model_g2b_ff", 32'(m_g2b(8'hFF)), 32'hAA);
    check("model_g2b_03", 32'(m_g2b(8'h03)), 32'h02);

    send(8'h0F, 1'b0); wait_out(8'h08, 1'b0, 1'b0, "b2g_0f");
    send(8'h01, 1'b1); wait_out(8'h01, 1'b1, 1'b0, "g2b_01");
    send(8'h03, 1'b1); wait_out(8'h02, 1'b1, 1'b0, "g2b_03");
    send(8'h00, 1'b1); wait_out(8'h00, 1'b1, 1'b1, "g2b_00_dist2");

    // Exhaustive round trip: binary -> Gray, then the Gray sequence back.
    out_count = 0;
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
    drain();
    check("b2g_all_count", out_count, 32'd256);
    out_count = 0;
    err_count = 0;
    for (int i = 0; i < 256; i++) send(m_b2g(8'(i)), 1'b1);
    drain();
    check("g2b_all_count", out_count, 32'd256);
    check("g2b_all_errs",  err_count, 32'd0);
    send(8'h00, 1'b1); wait_out(8'h00, 1'b1, 1'b0, "wrap_80_00");

    // Back-pressure for 5 cycles mid-stream.
    out_count   = 0;
    stall_count = 0;
    fork
      begin
        send(8'h10, 1'b1);
        send(8'h30, 1'b1);
        send(8'h20, 1'b1);
        send(8'h60, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", stall_count, 32'd5);
    check("stall_words", out_count, 32'd4);

    // Reset with two words in flight clears pipe and history.
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'hFF, 1'b1); wait_out(8'hAA, 1'b1, 1'b0, "ff_after_rst");

    // WIDTH=5 with STAGES=5 and STAGES=1 side by side.
    begin
      int k = 0;
      int lat_a = 0, lat_b = 0;
      logic [4:0] da = '0, db = '0;
      logic ea = 1'b1, eb = 1'b1, ma = 1'b0, mb = 1'b0;
      in5_data  = 5'b11000;
      in5_mode  = 1'b1;
      in5_valid = 1'b1;
      @(posedge clk); #1;
      in5_valid = 1'b0;
      while ((lat_a == 0 || lat_b == 0) && k < 20) begin
        @(negedge clk);
        if (lat_a == 0 && ov5a) begin lat_a = k + 1; da = od5a; ea = ae5a; ma = om5a; end
        if (lat_b == 0 && ov5b) begin lat_b = k + 1; db = od5b; eb = ae5b; mb = om5b; end
        k++;
      end
      $display("word w5s5 out=%02h lat=%0d ; w5s1 out=%02h lat=%0d", da, lat_a, db, lat_b);
      check("w5s5_lat",  lat_a, 32'd5);
      check("w5s5_data", 32'(da), 32'h10);
      check("w5s5_em",   32'({ea, ma}), 32'b01);
      check("w5s1_lat",  lat_b, 32'd1);
      check("w5s1_data", 32'(db), 32'h10);
      check("w5s1_em",   32'({eb, mb}), 32'b01);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
